mac_learn_table_aging: RTL and testbench

//  Learning MAC table for the output-port-lookup stage, successor to the two-CAM switch LUT.

---
 rtl/mac_learn_table_aging.sv | 244 ++++++++++++++++++++++++
 tb/tb_mac_learn_table_aging.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_learn_table_aging.sv
// Learning MAC table with per-entry aging, first-free allocation and station-move detection.
// Flop-based CAM plus port LUT; the top entry is a hard-wired broadcast route.
module mac_learn_table_aging #(
    parameter int unsigned                   NUM_OUTPUT_QUEUES         = 8,
    parameter int unsigned                   LUT_DEPTH_BITS            = 4,
    parameter logic [NUM_OUTPUT_QUEUES-1:0]  DEFAULT_MISS_OUTPUT_PORTS = NUM_OUTPUT_QUEUES'(8'h55),
    parameter int unsigned                   AGE_TICK_CYCLES           = 1024,
    parameter int unsigned                   AGE_MAX                   = 15,
    parameter bit                            MOVE_LOCK                 = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [47:0]                  dst_mac,
    input  logic [47:0]                  src_mac,
    input  logic [NUM_OUTPUT_QUEUES-1:0] src_port,
    input  logic                         lookup_req,
    output logic                         lookup_ready,
    output logic [NUM_OUTPUT_QUEUES-1:0] dst_ports,
    output logic                         lookup_done,
    output logic                         lut_hit,
    output logic                         lut_miss,
    output logic                         move_alarm,
    output logic                         table_full,
    output logic [LUT_DEPTH_BITS:0]      entry_count
);

    localparam int unsigned NOQ       = NUM_OUTPUT_QUEUES;
    localparam int unsigned DEPTH     = 1 << LUT_DEPTH_BITS;
    localparam int unsigned LEARN_N   = DEPTH - 1;
    localparam int unsigned IW        = LUT_DEPTH_BITS;
    localparam int unsigned CW        = LUT_DEPTH_BITS + 1;
    localparam int unsigned AW        = 4;
    localparam int unsigned PW        = (AGE_TICK_CYCLES > 1) ? $clog2(AGE_TICK_CYCLES) : 1;
    localparam int unsigned MCAST_BIT = 40;

    localparam logic [47:0]    BCAST_MAC  = '1;
    localparam logic [AW-1:0]  AGE_RELOAD = AW'(AGE_MAX);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(AGE_TICK_CYCLES - 1);
    localparam logic [IW-1:0]  PTR_LAST   = IW'(LEARN_N - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_LEARN  = 2'd2;

    logic [1:0]     state;
    logic [1:0]     state_next;

    logic [47:0]    dst_q;
    logic [47:0]    src_q;
    logic [NOQ-1:0] port_q;

    logic [LEARN_N-1:0] valid;
    logic [47:0]        mac       [LEARN_N];
    logic [NOQ-1:0]     ports_tab [LEARN_N];
    logic [AW-1:0]      age       [LEARN_N];

    logic [IW-1:0]  rr_ptr;
    logic [PW-1:0]  presc;
    logic           tick;

    logic           dst_hit_c;
    logic [IW-1:0]  dst_idx_c;
    logic [NOQ-1:0] dst_ports_c;
    logic           src_hit_c;
    logic [IW-1:0]  src_idx_c;

    logic           dst_hit_r;
    logic [NOQ-1:0] dst_ports_r;
    logic           src_hit_r;
    logic [IW-1:0]  src_idx_r;

    logic           free_found_c;
    logic [IW-1:0]  free_idx_c;
    logic [CW-1:0]  count_c;

    logic           moved_c;
    logic           wr_en;
    logic [IW-1:0]  wr_idx;
    logic           ptr_adv;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (lookup_req) state_next = S_LOOKUP;
            S_LOOKUP: state_next = S_LEARN;
            S_LEARN:  state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Request capture; requests outside IDLE are dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dst_q  <= '0;
            src_q  <= '0;
            port_q <= '0;
        end else if (state == S_IDLE && lookup_req) begin
            dst_q  <= dst_mac;
            src_q  <= src_mac;
            port_q <= src_port;
        end
    end

    // Parallel CAM compare; descending loop leaves the lowest matching index
    always_comb begin
        dst_hit_c = 1'b0;
        dst_idx_c = '0;
        src_hit_c = 1'b0;
        src_idx_c = '0;
        for (int i = int'(LEARN_N) - 1; i >= 0; i--) begin
            if (valid[i] && mac[i] == dst_q) begin
                dst_hit_c = 1'b1;
                dst_idx_c = IW'(i);
            end
            if (valid[i] && mac[i] == src_q) begin
                src_hit_c = 1'b1;
                src_idx_c = IW'(i);
            end
        end
        dst_ports_c = dst_hit_c ? ports_tab[dst_idx_c] : DEFAULT_MISS_OUTPUT_PORTS;
        if (dst_q == BCAST_MAC) begin
            dst_hit_c   = 1'b1;
            dst_ports_c = DEFAULT_MISS_OUTPUT_PORTS;
        end
    end

    // Lookup results are frozen here so a concurrent age-out cannot retract a hit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dst_hit_r   <= 1'b0;
            dst_ports_r <= '0;
            src_hit_r   <= 1'b0;
            src_idx_r   <= '0;
        end else if (state == S_LOOKUP) begin
            dst_hit_r   <= dst_hit_c;
            dst_ports_r <= dst_ports_c;
            src_hit_r   <= src_hit_c;
            src_idx_r   <= src_idx_c;
        end
    end

    // Lowest free learnable slot and occupancy
    always_comb begin
        free_found_c = 1'b0;
        free_idx_c   = '0;
        count_c      = '0;
        for (int i = int'(LEARN_N) - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_found_c = 1'b1;
                free_idx_c   = IW'(i);
            end
            count_c = count_c + CW'(valid[i]);
        end
    end

    // Learn decision: refresh, move handling or allocation
    always_comb begin
        moved_c = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = '0;
        ptr_adv = 1'b0;
        if (state == S_LEARN && !src_q[MCAST_BIT]) begin
            if (src_hit_r) begin
                moved_c = (ports_tab[src_idx_r] != port_q);
                wr_en   = !moved_c || !MOVE_LOCK;
                wr_idx  = src_idx_r;
            end else begin
                wr_en   = 1'b1;
                wr_idx  = free_found_c ? free_idx_c : rr_ptr;
                ptr_adv = !free_found_c;
            end
        end
    end

    // Aging prescaler
    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + PW'(1);
    end

    // Replacement pointer, used only when the table is full
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        rr_ptr <= '0;
        else if (ptr_adv) rr_ptr <= (rr_ptr == PTR_LAST) ? '0 : rr_ptr + IW'(1);
    end

    // Table storage; a learn write takes priority over an aging decrement
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
            for (int i = 0; i < int'(LEARN_N); i++) begin
                mac[i]       <= '0;
                ports_tab[i] <= '0;
                age[i]       <= '0;
            end
        end else begin
            for (int i = 0; i < int'(LEARN_N); i++) begin
                if (wr_en && wr_idx == IW'(i)) begin
                    valid[i]     <= 1'b1;
                    mac[i]       <= src_q;
                    ports_tab[i] <= port_q;
                    age[i]       <= AGE_RELOAD;
                end else if (tick && valid[i]) begin
                    age[i] <= age[i] - AW'(1);
                    if (age[i] <= AW'(1)) valid[i] <= 1'b0;
                end
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lookup_ready <= 1'b1;
            lookup_done  <= 1'b0;
            lut_hit      <= 1'b0;
            lut_miss     <= 1'b0;
            move_alarm   <= 1'b0;
            dst_ports    <= '0;
            entry_count  <= '0;
            table_full   <= 1'b0;
        end else begin
            lookup_ready <= (state_next == S_IDLE);
            lookup_done  <= (state == S_LEARN);
            lut_hit      <= (state == S_LEARN) && dst_hit_r;
            lut_miss     <= (state == S_LEARN) && !dst_hit_r;
            move_alarm   <= moved_c;
            if (state == S_LEARN) dst_ports <= dst_ports_r & ~port_q;
            entry_count  <= count_c;
            table_full   <= &valid;
        end
    end

endmodule

// File: tb/tb_mac_learn_table_aging.sv
// Directed bench for mac_learn_table_aging: three instances (move-lock, move-relearn,
// fast aging) share one stimulus stream; each check targets the relevant instance.
module tb_mac_learn_table_aging;

    logic        clk = 1'b0;
    logic        reset;
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [7:0]  src_port;
    logic        lookup_req;

    logic [2:0]      ready_w, done_w, hit_w, miss_w, move_w, full_w;
    logic [2:0][7:0] ports_w;
    logic [2:0][4:0] count_w;

    logic [2:0]      r_done, r_hit, r_miss, r_move;
    logic [2:0][7:0] r_ports;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] MC    = 48'h0100_5E00_0001;
    localparam logic [47:0] MAC_A = 48'h0011_2233_4455;
    localparam logic [47:0] MAC_B = 48'h00AA_BBCC_DDEE;
    localparam logic [47:0] MAC_C = 48'h0000_0000_00CC;
    localparam logic [47:0] MAC_D = 48'h0000_0000_0077;
    localparam logic [47:0] FILL  = 48'h0200_0000_0000;

    always #5 clk = ~clk;

    mac_learn_table_aging dut_lock (
        .clk(clk), .reset(reset), .dst_mac(dst_mac), .src_mac(src_mac), .src_port(src_port),
        .lookup_req(lookup_req), .lookup_ready(ready_w[0]), .dst_ports(ports_w[0]),
        .lookup_done(done_w[0]), .lut_hit(hit_w[0]), .lut_miss(miss_w[0]),
        .move_alarm(move_w[0]), .table_full(full_w[0]), .entry_count(count_w[0]));

    mac_learn_table_aging #(.MOVE_LOCK(1'b0)) dut_relearn (
        .clk(clk), .reset(reset), .dst_mac(dst_mac), .src_mac(src_mac), .src_port(src_port),
        .lookup_req(lookup_req), .lookup_ready(ready_w[1]), .dst_ports(ports_w[1]),
        .lookup_done(done_w[1]), .lut_hit(hit_w[1]), .lut_miss(miss_w[1]),
        .move_alarm(move_w[1]), .table_full(full_w[1]), .entry_count(count_w[1]));

    mac_learn_table_aging #(.AGE_TICK_CYCLES(4), .AGE_MAX(2)) dut_age (
        .clk(clk), .reset(reset), .dst_mac(dst_mac), .src_mac(src_mac), .src_port(src_port),
        .lookup_req(lookup_req), .lookup_ready(ready_w[2]), .dst_ports(ports_w[2]),
        .lookup_done(done_w[2]), .lut_hit(hit_w[2]), .lut_miss(miss_w[2]),
        .move_alarm(move_w[2]), .table_full(full_w[2]), .entry_count(count_w[2]));

    typedef struct {
        string       name;
        logic [47:0] dst;
        logic [47:0] src;
        logic [7:0]  port;
        logic        hit;
        logic [7:0]  ports0;
        logic        move0;
        logic [7:0]  ports1;
        logic        move1;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One request; results captured one cycle after the LEARN state
    task automatic do_req(input logic [47:0] d, input logic [47:0] s, input logic [7:0] p);
        @(negedge clk);
        dst_mac    = d;
        src_mac    = s;
        src_port   = p;
        lookup_req = 1'b1;
        @(posedge clk);
        #1 lookup_req = 1'b0;
        check("done_early_lookup", 64'(done_w[0]), 64'd0);
        @(posedge clk);
        #1 check("done_early_learn", 64'(done_w[0]), 64'd0);
        @(posedge clk);
        #1;
        r_done  = done_w;
        r_hit   = hit_w;
        r_miss  = miss_w;
        r_move  = move_w;
        r_ports = ports_w;
        check("done_at_3", 64'(r_done[0]), 64'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        lookup_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        lookup_req = 1'b0;
        dst_mac    = '0;
        src_mac    = '0;
        src_port   = '0;

        vecs[0] = '{"bcast",       BCAST, MC,    8'h01, 1'b1, 8'h54, 1'b0, 8'h54, 1'b0};
        vecs[1] = '{"learn_a",     MAC_C, MAC_A, 8'h04, 1'b0, 8'h51, 1'b0, 8'h51, 1'b0};
        vecs[2] = '{"hit_a",       MAC_A, MAC_B, 8'h01, 1'b1, 8'h04, 1'b0, 8'h04, 1'b0};
        vecs[3] = '{"hit_b",       MAC_B, MAC_A, 8'h04, 1'b1, 8'h01, 1'b0, 8'h01, 1'b0};
        vecs[4] = '{"move_a",      MAC_A, MAC_A, 8'h10, 1'b1, 8'h04, 1'b1, 8'h04, 1'b1};
        vecs[5] = '{"after_move",  MAC_A, MC,    8'h01, 1'b1, 8'h04, 1'b0, 8'h10, 1'b0};
        vecs[6] = '{"move_back",   MAC_A, MAC_A, 8'h04, 1'b1, 8'h00, 1'b0, 8'h10, 1'b1};
        vecs[7] = '{"miss_move_b", MAC_D, MAC_B, 8'h02, 1'b0, 8'h55, 1'b1, 8'h55, 1'b1};
        vecs[8] = '{"hit_b_moved", MAC_B, MC,    8'h04, 1'b1, 8'h01, 1'b0, 8'h02, 1'b0};

        // Reset state
        do_reset();
        check("rst_ready", 64'(ready_w[0]), 64'd1);
        check("rst_done",  64'(done_w[0]),  64'd0);
        check("rst_count", 64'(count_w[0]), 64'd0);
        check("rst_full",  64'(full_w[0]),  64'd0);
        check("rst_ports", 64'(ports_w[0]), 64'd0);

        // Basic lookup, learning and station-move vectors
        for (int v = 0; v < 9; v++) begin
            do_req(vecs[v].dst, vecs[v].src, vecs[v].port);
            check({vecs[v].name, "_hit"},    64'(r_hit[0]),   64'(vecs[v].hit));
            check({vecs[v].name, "_miss"},   64'(r_miss[0]),  64'(!vecs[v].hit));
            check({vecs[v].name, "_ports0"}, 64'(r_ports[0]), 64'(vecs[v].ports0));
            check({vecs[v].name, "_move0"},  64'(r_move[0]),  64'(vecs[v].move0));
            check({vecs[v].name, "_ports1"}, 64'(r_ports[1]), 64'(vecs[v].ports1));
            check({vecs[v].name, "_move1"},  64'(r_move[1]),  64'(vecs[v].move1));
        end
        idle(2);
        check("count_ab_lock",    64'(count_w[0]), 64'd2);
        check("count_ab_relearn", 64'(count_w[1]), 64'd2);
        check("done_cleared",     64'(done_w[0]),  64'd0);

        // Fill all learnable entries, then round-robin replacement
        do_reset();
        for (int i = 0; i < 15; i++) do_req(BCAST, FILL | 48'(i), 8'h08);
        idle(2);
        check("fill_count", 64'(count_w[0]), 64'd15);
        check("fill_full",  64'(full_w[0]),  64'd1);
        do_req(BCAST, FILL | 48'h100, 8'h02);
        do_req(FILL, MC, 8'h01);
        check("evict_e0_miss", 64'(r_miss[0]), 64'd1);
        do_req(FILL | 48'd1, MC, 8'h01);
        check("keep_e1_hit",   64'(r_hit[0]),   64'd1);
        check("keep_e1_ports", 64'(r_ports[0]), 64'h08);
        do_req(BCAST, FILL | 48'h200, 8'h02);
        do_req(FILL | 48'd1, MC, 8'h01);
        check("evict_e1_miss", 64'(r_miss[0]), 64'd1);
        do_req(FILL | 48'h100, MC, 8'h01);
        check("new_x_hit",   64'(r_hit[0]),   64'd1);
        check("new_x_ports", 64'(r_ports[0]), 64'h02);
        for (int k = 2; k < 15; k++) do_req(BCAST, FILL | 48'h300 | 48'(k), 8'h04);
        do_req(BCAST, FILL | 48'h400, 8'h04);
        do_req(FILL | 48'h100, MC, 8'h01);
        check("wrap_evict_x", 64'(r_miss[0]), 64'd1);
        do_req(FILL | 48'h200, MC, 8'h01);
        check("wrap_keep_y", 64'(r_hit[0]), 64'd1);
        idle(2);
        check("wrap_count", 64'(count_w[0]), 64'd15);
        check("wrap_full",  64'(full_w[0]),  64'd1);

        // Aging on the fast-tick instance
        do_reset();
        do_req(BCAST, MAC_A, 8'h04);
        idle(1);
        check("age_learned", 64'(count_w[2]), 64'd1);
        idle(12);
        check("age_expired", 64'(count_w[2]), 64'd0);
        check("age_slow_kept", 64'(count_w[0]), 64'd1);
        do_req(MAC_A, MC, 8'h01);
        check("age_dst_miss", 64'(r_miss[2]), 64'd1);
        check("age_slow_hit", 64'(r_hit[0]),  64'd1);
        for (int k = 0; k < 6; k++) do_req(MAC_A, MAC_A, 8'h04);
        check("refresh_hit", 64'(r_hit[2]), 64'd1);
        idle(1);
        check("refresh_count", 64'(count_w[2]), 64'd1);

        // Reset while a request is in LOOKUP
        do_reset();
        @(negedge clk);
        dst_mac    = BCAST;
        src_mac    = MAC_A;
        src_port   = 8'h04;
        lookup_req = 1'b1;
        @(posedge clk);
        #1 lookup_req = 1'b0;
        reset = 1'b1;
        #1;
        check("abort_ready", 64'(ready_w[0]), 64'd1);
        begin
            logic seen_done;
            seen_done = 1'b0;
            @(negedge clk);
            reset = 1'b0;
            repeat (4) begin
                @(posedge clk);
                #1 seen_done = seen_done | done_w[0];
            end
            check("abort_no_done", 64'(seen_done), 64'd0);
        end
        check("abort_count", 64'(count_w[0]), 64'd0);
        check("abort_ready_after", 64'(ready_w[0]), 64'd1);
        do_req(MAC_A, MC, 8'h01);
        check("abort_not_learned", 64'(r_miss[0]),  64'd1);
        check("abort_miss_ports",  64'(r_ports[0]), 64'h54);
        do_req(BCAST, MAC_A, 8'h04);
        idle(2);
        check("post_abort_count", 64'(count_w[0]), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
